// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding select encodings and the PC register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEMWAIT  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned PC_REG = 15;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one Execute-stage source register.
// Memory-stage results win over Writeback; the PC register is never forwarded.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 4
) (
    input  logic [REG_W-1:0] ra,
    input  logic [REG_W-1:0] wa3m,
    input  logic [REG_W-1:0] wa3w,
    input  logic             regwritem,
    input  logic             regwritew,
    output logic [1:0]       fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (ra != REG_W'(PC_REG)) begin
            if (regwritem && (wa3m == ra)) begin
                fwd = FWD_MEM;
            end else if (regwritew && (wa3w == ra)) begin
                fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, memory-wait / branch /
// load-use stall and flush sequencing, and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RA1E,
    input  logic [REG_W-1:0] RA2E,
    input  logic [REG_W-1:0] WA3E,
    input  logic [REG_W-1:0] WA3M,
    input  logic [REG_W-1:0] WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount
);

    state_t     state, state_nx;
    logic [1:0] fwd_a, fwd_b;
    logic       load_use;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .ra        (RA1E),
        .wa3m      (WA3M),
        .wa3w      (WA3W),
        .regwritem (RegWriteM),
        .regwritew (RegWriteW),
        .fwd       (fwd_a)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .ra        (RA2E),
        .wa3m      (WA3M),
        .wa3w      (WA3W),
        .regwritem (RegWriteM),
        .regwritew (RegWriteW),
        .fwd       (fwd_b)
    );

    assign load_use = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    {StallF, StallD, StallE, StallM, FlushW} = '1;
                    state_nx = MEMWAIT;
                end else if (BranchTakenE) begin
                    FlushD   = 1'b1;
                    FlushE   = 1'b1;
                    state_nx = REDIRECT;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MEMWAIT: begin
                // Branch/load-use inputs stay frozen and are seen again in RUN.
                if (!MemReadyM) begin
                    {StallF, StallD, StallE, StallM, FlushW} = '1;
                end else begin
                    state_nx = RUN;
                end
            end
            REDIRECT: begin
                FlushD   = 1'b1;
                state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
        if (!reset) begin
            {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} = '0;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCount <= '0;
        end else if ((StallF || StallM) && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl: forwarding, load-use, branch, memory wait,
// priority, reset abandonment and stall-counter saturation.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.REG_W(4), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .BranchTakenE (BranchTakenE),
        .MemReqM      (MemReqM),
        .MemReadyM    (MemReadyM),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallCount   (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stalls = {StallF,StallD,StallE,StallM,FlushW}, flush = {FlushD,FlushE}
    task automatic chk_ctl(input string tag, input logic [4:0] stalls, input logic [1:0] flush);
        chk({tag, "_stall"}, 32'({StallF, StallD, StallE, StallM, FlushW}), 32'(stalls));
        chk({tag, "_flush"}, 32'({FlushD, FlushE}), 32'(flush));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
        WA3E = 4'd9; WA3M = '0; WA3W = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #3;
        // Reset dominates every input
        RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
        MemReqM = 1'b1; BranchTakenE = 1'b1;
        MemtoRegE = 1'b1; WA3E = 4'd0;
        #1;
        chk_ctl("rst", 5'b00000, 2'b00);
        chk("rst_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
        chk("rst_cnt", 32'(StallCount), 32'd0);
        tick();
        clear_inputs();
        reset = 1'b1;
        #1;
        chk_ctl("run_idle", 5'b00000, 2'b00);

        // Forwarding
        RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3;
        RA1E = 4'd3; RA2E = 4'd4;
        #1;
        chk("fwd_mem_a", 32'(ForwardAE), 32'd2);
        chk("fwd_none_b", 32'(ForwardBE), 32'd0);
        RegWriteM = 1'b0; RA2E = 4'd3;
        #1;
        chk("fwd_wb_a", 32'(ForwardAE), 32'd1);
        chk("fwd_wb_b", 32'(ForwardBE), 32'd1);
        RegWriteM = 1'b1; WA3M = 4'd15; WA3W = 4'd15; RA1E = 4'd15; RA2E = 4'd15;
        #1;
        chk("fwd_pc", 32'({ForwardAE, ForwardBE}), 32'd0);
        tick();
        clear_inputs();

        // Load-use: one-cycle bubble, counter +1
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
        #1;
        chk_ctl("lu", 5'b11000, 2'b01);
        tick();
        clear_inputs();
        #1;
        chk_ctl("lu_after", 5'b00000, 2'b00);
        chk("lu_cnt", 32'(StallCount), 32'd1);

        // Branch; REDIRECT ignores memory request and load-use
        BranchTakenE = 1'b1;
        #1;
        chk_ctl("br_c0", 5'b00000, 2'b11);
        tick();
        BranchTakenE = 1'b0; MemReqM = 1'b1;
        MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
        #1;
        chk_ctl("br_c1", 5'b00000, 2'b10);
        tick();
        clear_inputs();
        #1;
        chk_ctl("br_c2", 5'b00000, 2'b00);
        chk("br_cnt", 32'(StallCount), 32'd1);

        // Memory wait for three cycles
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctl($sformatf("mw_%0d", i), 5'b11111, 2'b00);
            tick();
        end
        MemReadyM = 1'b1;
        #1;
        chk_ctl("mw_ready", 5'b00000, 2'b00);
        tick();
        clear_inputs();
        #1;
        chk_ctl("mw_after", 5'b00000, 2'b00);
        chk("mw_cnt", 32'(StallCount), 32'd4);

        // Memory wait beats branch; branch handled after exit
        MemReqM = 1'b1; MemReadyM = 1'b0; BranchTakenE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_ctl($sformatf("pri_wait_%0d", i), 5'b11111, 2'b00);
            tick();
        end
        MemReadyM = 1'b1;
        #1;
        chk_ctl("pri_ready", 5'b00000, 2'b00);
        tick();
        MemReqM = 1'b0; MemReadyM = 1'b0;
        #1;
        chk_ctl("pri_br", 5'b00000, 2'b11);
        tick();
        BranchTakenE = 1'b0;
        #1;
        chk_ctl("pri_redir", 5'b00000, 2'b10);
        tick();
        #1;
        chk_ctl("pri_done", 5'b00000, 2'b00);
        chk("pri_cnt", 32'(StallCount), 32'd6);

        // Reset in MEMWAIT abandons the wait
        MemReqM = 1'b1; MemReadyM = 1'b0;
        tick();
        chk_ctl("rmw_wait", 5'b11111, 2'b00);
        reset = 1'b0;
        #1;
        chk_ctl("rmw_rst", 5'b00000, 2'b00);
        chk("rmw_cnt", 32'(StallCount), 32'd0);
        tick();
        MemReqM = 1'b0; BranchTakenE = 1'b1;
        reset = 1'b1;
        #1;
        chk_ctl("rmw_run", 5'b00000, 2'b11);
        tick();
        BranchTakenE = 1'b0;
        #1;
        chk_ctl("rmw_redir", 5'b00000, 2'b10);

        // Reset in REDIRECT abandons the redirect
        reset = 1'b0;
        #1;
        chk_ctl("rrd_rst", 5'b00000, 2'b00);
        tick();
        reset = 1'b1;
        #1;
        chk_ctl("rrd_run", 5'b00000, 2'b00);
        tick();

        // Saturation: long memory wait drives the counter to all-ones
        clear_inputs();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (65533) tick();
        chk("sat_pre", 32'(StallCount), 32'd65533);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("sat_%0d", i), 32'(StallCount), (65533 + i > 65535) ? 32'd65535 : 32'(65533 + i));
        end
        chk_ctl("sat_stall", 5'b11111, 2'b00);
        clear_inputs();
        MemReadyM = 1'b1;
        tick();
        chk("sat_hold", 32'(StallCount), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 4: register-address width.
REQ-002 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports RA1D, RA2D  in  REG_W  Decode-stage source registers.
REQ-006 SHALL have ports RA1E, RA2E  in  REG_W  Execute-stage source registers.
REQ-007 SHALL have ports WA3E, WA3M, WA3W  in  REG_W  destination registers in Execute, Memory and Writeback.
REQ-008 SHALL have ports RegWriteM, RegWriteW  in  1  the Memory or Writeback instruction writes the register file.
REQ-009 SHALL have port MemtoRegE  in  1  the Execute instruction is a load.
REQ-010 SHALL have port BranchTakenE  in  1  the Execute stage redirects the PC.
REQ-011 SHALL have port MemReqM  in  1  the Memory stage accesses data memory.
REQ-012 SHALL have port MemReadyM  in  1  the data memory completes the access this cycle.
REQ-013 SHALL have ports StallF, StallD, StallE, StallM  out  1  hold the PC or the named pipeline register.
REQ-014 SHALL have ports FlushD, FlushE, FlushW  out  1  zero the named pipeline register on the next edge.
REQ-015 SHALL have ports ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 Writeback, 10 Memory.
REQ-016 SHALL have port StallCount  out  CNT_W  performance counter of stalled cycles.

Function
REQ-017 SHALL drive ForwardAE=10 when RegWriteM, WA3M==RA1E and RA1E!=15; else 01 when RegWriteW, WA3W==RA1E and RA1E!=15; else 00. ForwardBE SHALL use the same rule with RA2E. Forwarding SHALL be combinational.
REQ-018 SHALL implement FSM states RUN, MEMWAIT and REDIRECT.
REQ-019 In RUN with MemReqM=1 and MemReadyM=0, SHALL assert StallF, StallD, StallE, StallM and FlushW in the same cycle, then go to MEMWAIT.
REQ-020 In MEMWAIT, SHALL hold those five outputs asserted until a cycle with MemReadyM=1; in that cycle all five SHALL deassert and the next state SHALL be RUN.
REQ-021 In RUN with BranchTakenE=1 and no memory wait, SHALL assert FlushD and FlushE for one cycle, then go to REDIRECT.
REQ-022 REDIRECT SHALL last exactly one cycle: FlushD=1, all other outputs 0, then return to RUN. In REDIRECT, BranchTakenE, MemtoRegE and MemReqM SHALL be ignored.
REQ-023 In RUN with MemtoRegE=1, WA3E equal to RA1D or RA2D, and no branch or memory wait, SHALL assert StallF, StallD and FlushE for exactly one cycle; the state stays RUN.
REQ-024 Priority SHALL be memory wait > branch > load-use. A branch or load-use present during MEMWAIT is frozen in its stage and SHALL be evaluated in the first RUN cycle after exit.
REQ-025 StallF SHALL equal StallD in every cycle.
REQ-026 StallCount SHALL increment by 1 in every cycle in which StallF or StallM is 1, and SHALL saturate at all-ones without wrapping.

Reset
REQ-027 While reset=0, SHALL force the state to RUN and StallCount to 0, and SHALL force all Stall/Flush outputs to 0 and ForwardAE/ForwardBE to 00, regardless of inputs.
REQ-028 SHALL support reset asserted mid-MEMWAIT or mid-REDIRECT: that operation is abandoned immediately, and the first cycle after reset release is a normal RUN cycle.

Structure
REQ-029 SHALL take the FSM state enum, the forwarding select encodings (FWD_RF, FWD_WB, FWD_MEM) and the PC register index 15 from a shared package, hazard_pkg.
REQ-030 SHALL place forwarding in one sub-module, fwd_unit, instantiated once per operand; the FSM and the counter stay in hazard_ctrl.

Verification
REQ-031 Bench SHALL check forwarding: RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10. The same with RA1E=RA2E=15 -> ForwardAE=ForwardBE=00.
REQ-032 Bench SHALL check load-use: MemtoRegE=1, WA3E=5, RA2D=5 for one cycle -> StallF=StallD=FlushE=1 for one cycle, StallCount +1.
REQ-033 Bench SHALL check branch: BranchTakenE=1 for one cycle -> FlushD=FlushE=1 in cycle 0, FlushD=1 only in cycle 1, all flushes 0 in cycle 2.
REQ-034 Bench SHALL check memory wait: MemReqM=1 with MemReadyM=0 for 3 cycles, then MemReadyM=1 -> StallF/D/E/M and FlushW high for exactly 3 cycles, StallCount=3.
REQ-035 Bench SHALL check priority: MemReqM=1, MemReadyM=0 and BranchTakenE=1 together -> no flush during the wait; FlushD=FlushE=1 in the first cycle after MemReadyM=1.
REQ-036 Bench SHALL check reset and saturation: reset=0 in MEMWAIT -> all outputs 0 at once and RUN after release. StallCount preloaded near all-ones and stalled for 5 cycles -> holds at 0xFFFF.
